blk_ba51ab: RTL and testbench

//  Parametrised N-input, WIDTH-bit select mux for memory BIST assembly paths (BIST vs functional vs diag).

---
 rtl/blk_ba51ab.sv | 138 +++++++++++++
 tb/tb_blk_ba51ab.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/blk_ba51ab.sv
// N-input select mux with a blanking window on every select change.
// The optional output register gives downstream memory collars retimed data.
module blk_ba51ab #(
    parameter int WIDTH         = 1,
    parameter int NUM_INPUTS    = 2,
    parameter int SEL_W         = 1,
    parameter int RESET_SEL     = 0,
    parameter int SETTLE_CYCLES = 2,
    parameter int REG_OUT       = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_INPUTS*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]            sel_req,
    input  logic                        sel_req_valid,
    output logic                        sel_req_ready,
    output logic [SEL_W-1:0]            sel_active,
    output logic                        switching,
    output logic [WIDTH-1:0]            data_out,
    output logic                        data_out_valid,
    output logic                        sel_err
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam int SLOTS = 2 ** SEL_W;
    localparam logic [SEL_W:0]       NUM_IN_C    = (SEL_W + 1)'(NUM_INPUTS);
    localparam logic [SEL_W-1:0]     RESET_SEL_C = SEL_W'(RESET_SEL);
    localparam logic [CNT_W-1:0]     CNT_LOAD_C  = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BLANK = 1'b1
    } state_t;

    state_t            state_r;
    logic [SEL_W-1:0]  sel_active_r;
    logic [SEL_W-1:0]  sel_pend_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [WIDTH-1:0]  data_r;
    logic              valid_r;
    logic              sel_err_r;

    logic [WIDTH-1:0]  slot_s [SLOTS];
    logic [WIDTH-1:0]  mux_s;
    logic              idle_s;
    logic              req_fire_s;
    logic              req_bad_s;
    logic              req_switch_s;

    // Unused select codes read as zero so the mux index never leaves the array.
    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        if (i < NUM_INPUTS) begin : g_used
            assign slot_s[i] = data_in[i*WIDTH +: WIDTH];
        end else begin : g_pad
            assign slot_s[i] = {WIDTH{1'b0}};
        end
    end

    assign mux_s  = slot_s[sel_active_r];
    assign idle_s = (state_r == IDLE);

    // Classify the request presented in this cycle.
    always_comb begin
        req_fire_s   = 1'b0;
        req_bad_s    = 1'b0;
        req_switch_s = 1'b0;
        if (sel_req_valid && idle_s) begin
            req_fire_s   = 1'b1;
            req_bad_s    = ({1'b0, sel_req} >= NUM_IN_C);
            req_switch_s = !req_bad_s && (sel_req != sel_active_r);
        end else begin
            req_fire_s   = 1'b0;
        end
    end

    // Select-change FSM: accept, blank for SETTLE_CYCLES, then commit the new index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            sel_active_r <= RESET_SEL_C;
            sel_pend_r   <= RESET_SEL_C;
            cnt_r        <= {CNT_W{1'b0}};
            sel_err_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_fire_s && req_bad_s) begin
                        sel_err_r <= 1'b1;
                    end else if (req_switch_s) begin
                        sel_pend_r <= sel_req;
                        cnt_r      <= CNT_LOAD_C;
                        state_r    <= BLANK;
                    end
                end
                BLANK: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        sel_active_r <= sel_pend_r;
                        state_r      <= IDLE;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Output register: tracks the mux while idle, freezes during blanking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_r  <= {WIDTH{1'b0}};
            valid_r <= 1'b0;
        end else if (idle_s) begin
            data_r  <= mux_s;
            valid_r <= !req_switch_s;
        end else begin
            valid_r <= 1'b0;
        end
    end

    if (REG_OUT != 0) begin : g_reg_out
        assign data_out       = data_r;
        assign data_out_valid = valid_r;
    end else begin : g_comb_out
        // The frozen register value covers blanking and reset.
        assign data_out       = (idle_s && !reset) ? mux_s : data_r;
        assign data_out_valid = idle_s && !reset;
    end

    assign sel_req_ready = idle_s;
    assign switching     = (state_r == BLANK);
    assign sel_active    = sel_active_r;
    assign sel_err       = sel_err_r;

endmodule

// File: tb/tb_blk_ba51ab.sv
// Directed bench for blk_ba51ab: three parameterisations share one clock and reset.
module tb_blk_ba51ab;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // A: 4 inputs, reset select 2, S=2, registered output
    logic [31:0] a_data_in;
    logic [1:0]  a_sel_req, a_sel_active;
    logic        a_sel_req_valid, a_ready, a_switching, a_valid, a_sel_err;
    logic [7:0]  a_data_out;
    // B: 3 inputs, registered output
    logic [23:0] b_data_in;
    logic [1:0]  b_sel_req, b_sel_active;
    logic        b_sel_req_valid, b_ready, b_switching, b_valid, b_sel_err;
    logic [7:0]  b_data_out;
    // C: 4 inputs, S=1, combinational output
    logic [31:0] c_data_in;
    logic [1:0]  c_sel_req, c_sel_active;
    logic        c_sel_req_valid, c_ready, c_switching, c_valid, c_sel_err;
    logic [7:0]  c_data_out;

    blk_ba51ab #(.WIDTH(8), .NUM_INPUTS(4), .SEL_W(2), .RESET_SEL(2),
                 .SETTLE_CYCLES(2), .REG_OUT(1)) u_a (
        .clk(clk), .reset(reset), .data_in(a_data_in), .sel_req(a_sel_req),
        .sel_req_valid(a_sel_req_valid), .sel_req_ready(a_ready),
        .sel_active(a_sel_active), .switching(a_switching), .data_out(a_data_out),
        .data_out_valid(a_valid), .sel_err(a_sel_err));

    blk_ba51ab #(.WIDTH(8), .NUM_INPUTS(3), .SEL_W(2), .RESET_SEL(0),
                 .SETTLE_CYCLES(2), .REG_OUT(1)) u_b (
        .clk(clk), .reset(reset), .data_in(b_data_in), .sel_req(b_sel_req),
        .sel_req_valid(b_sel_req_valid), .sel_req_ready(b_ready),
        .sel_active(b_sel_active), .switching(b_switching), .data_out(b_data_out),
        .data_out_valid(b_valid), .sel_err(b_sel_err));

    blk_ba51ab #(.WIDTH(8), .NUM_INPUTS(4), .SEL_W(2), .RESET_SEL(0),
                 .SETTLE_CYCLES(1), .REG_OUT(0)) u_c (
        .clk(clk), .reset(reset), .data_in(c_data_in), .sel_req(c_sel_req),
        .sel_req_valid(c_sel_req_valid), .sel_req_ready(c_ready),
        .sel_active(c_sel_active), .switching(c_switching), .data_out(c_data_out),
        .data_out_valid(c_valid), .sel_err(c_sel_err));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge (inputs are driven here).
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        a_data_in = 32'h44332211; a_sel_req = 2'd0; a_sel_req_valid = 1'b0;
        b_data_in = 24'h332211;   b_sel_req = 2'd0; b_sel_req_valid = 1'b0;
        c_data_in = 32'h44332211; c_sel_req = 2'd0; c_sel_req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Test 1: reset release, cycle 1 then cycle 2
        @(negedge clk);
        chk("t1_c1_sel_active", 32'(a_sel_active), 32'd2);
        chk("t1_c1_data_out",   32'(a_data_out),   32'h00);
        chk("t1_c1_valid",      32'(a_valid),      32'd0);
        chk("t1_c1_ready",      32'(a_ready),      32'd1);
        chk("t1_c1_switching",  32'(a_switching),  32'd0);
        chk("t1_c1_sel_err",    32'(a_sel_err),    32'd0);
        chk("t1_c1_comb_data",  32'(c_data_out),   32'h11);
        chk("t1_c1_comb_valid", 32'(c_valid),      32'd1);
        cyc();
        @(negedge clk);
        chk("t1_c2_data_out",   32'(a_data_out),   32'h33);
        chk("t1_c2_valid",      32'(a_valid),      32'd1);

        // Test 2: switch A 2->1, accepted at edge ending T
        cyc();
        a_sel_req = 2'd1; a_sel_req_valid = 1'b1;
        @(negedge clk);
        chk("t2_T_ready",       32'(a_ready),      32'd1);
        cyc();
        a_sel_req_valid = 1'b0;
        @(negedge clk);
        chk("t2_T1_switching",  32'(a_switching),  32'd1);
        chk("t2_T1_valid",      32'(a_valid),      32'd0);
        chk("t2_T1_ready",      32'(a_ready),      32'd0);
        chk("t2_T1_data_frz",   32'(a_data_out),   32'h33);
        chk("t2_T1_sel_active", 32'(a_sel_active), 32'd2);
        cyc();
        @(negedge clk);
        chk("t2_T2_switching",  32'(a_switching),  32'd1);
        chk("t2_T2_valid",      32'(a_valid),      32'd0);
        chk("t2_T2_data_frz",   32'(a_data_out),   32'h33);
        cyc();
        @(negedge clk);
        chk("t2_T3_switching",  32'(a_switching),  32'd0);
        chk("t2_T3_sel_active", 32'(a_sel_active), 32'd1);
        chk("t2_T3_valid",      32'(a_valid),      32'd0);
        cyc();
        @(negedge clk);
        chk("t2_T4_data_out",   32'(a_data_out),   32'h22);
        chk("t2_T4_valid",      32'(a_valid),      32'd1);

        // Test 3: request equal to sel_active is a no-op
        cyc();
        a_sel_req = 2'd1; a_sel_req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_ready",      32'(a_ready),      32'd1);
            chk("t3_switching",  32'(a_switching),  32'd0);
            chk("t3_valid",      32'(a_valid),      32'd1);
            chk("t3_sel_active", 32'(a_sel_active), 32'd1);
            cyc();
        end
        a_sel_req_valid = 1'b0;

        // Test 4: out-of-range request on the 3-input instance
        b_sel_req = 2'd3; b_sel_req_valid = 1'b1;
        @(negedge clk);
        chk("t4_T_sel_err",     32'(b_sel_err),    32'd0);
        cyc();
        b_sel_req_valid = 1'b0;
        @(negedge clk);
        chk("t4_T1_sel_err",    32'(b_sel_err),    32'd1);
        chk("t4_T1_switching",  32'(b_switching),  32'd0);
        chk("t4_T1_sel_active", 32'(b_sel_active), 32'd0);
        chk("t4_T1_valid",      32'(b_valid),      32'd1);
        cyc();
        @(negedge clk);
        chk("t4_T2_sel_err",    32'(b_sel_err),    32'd1);
        chk("t4_T2_ready",      32'(b_ready),      32'd1);

        // Test 5: reset during blanking on A (1->3)
        cyc();
        a_sel_req = 2'd3; a_sel_req_valid = 1'b1;
        cyc();
        a_sel_req_valid = 1'b0;
        @(negedge clk);
        chk("t5_blank_switching", 32'(a_switching), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("t5_rst_switching",  32'(a_switching),  32'd0);
        chk("t5_rst_sel_active", 32'(a_sel_active), 32'd2);
        chk("t5_rst_data_out",   32'(a_data_out),   32'h00);
        chk("t5_rst_valid",      32'(a_valid),      32'd0);
        chk("t5_rst_ready",      32'(a_ready),      32'd1);
        chk("t5_rst_sel_err_b",  32'(b_sel_err),    32'd0);
        chk("t5_rst_comb_valid", 32'(c_valid),      32'd0);
        chk("t5_rst_comb_data",  32'(c_data_out),   32'h00);
        cyc();
        reset = 1'b0;
        @(negedge clk);
        chk("t5_c1_sel_active",  32'(a_sel_active), 32'd2);
        chk("t5_c1_data_out",    32'(a_data_out),   32'h00);
        chk("t5_c1_valid",       32'(a_valid),      32'd0);
        cyc();
        @(negedge clk);
        chk("t5_c2_data_out",    32'(a_data_out),   32'h33);
        chk("t5_c2_valid",       32'(a_valid),      32'd1);

        // Test 6: combinational output, S=1, switch 0->3 with valid held
        cyc();
        c_sel_req = 2'd3; c_sel_req_valid = 1'b1;
        @(negedge clk);
        chk("t6_T_ready",        32'(c_ready),      32'd1);
        chk("t6_T_data_out",     32'(c_data_out),   32'h11);
        cyc();
        @(negedge clk);
        chk("t6_T1_switching",   32'(c_switching),  32'd1);
        chk("t6_T1_ready",       32'(c_ready),      32'd0);
        chk("t6_T1_valid",       32'(c_valid),      32'd0);
        chk("t6_T1_data_frz",    32'(c_data_out),   32'h11);
        cyc();
        @(negedge clk);
        chk("t6_T2_sel_active",  32'(c_sel_active), 32'd3);
        chk("t6_T2_data_out",    32'(c_data_out),   32'h44);
        chk("t6_T2_valid",       32'(c_valid),      32'd1);
        chk("t6_T2_ready",       32'(c_ready),      32'd1);
        chk("t6_T2_switching",   32'(c_switching),  32'd0);
        cyc();
        @(negedge clk);
        chk("t6_T3_switching",   32'(c_switching),  32'd0);
        chk("t6_T3_valid",       32'(c_valid),      32'd1);
        chk("t6_T3_sel_active",  32'(c_sel_active), 32'd3);
        c_sel_req_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
